// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD write path.
// Holds the HD44780 command bytes, the arbiter FSM state encoding, the bus
// transfer phase encoding and small helpers that build command bytes.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_DDRAM   = 8'h80;
    localparam logic [7:0] LCD_ROW1_BASE   = 8'h40;

    // Arbiter FSM states
    localparam logic [1:0] ST_INIT_XFER = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_ADDR_XFER = 2'd2;
    localparam logic [1:0] ST_DATA_XFER = 2'd3;

    // Bus transfer phases
    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_SETUP = 2'd1;
    localparam logic [1:0] PH_PULSE = 2'd2;
    localparam logic [1:0] PH_HOLD  = 2'd3;

    // Set-DDRAM-address command for a {row, col[3:0]} position
    function automatic logic [7:0] ddram_cmd(input logic [4:0] pos);
        ddram_cmd = LCD_CMD_DDRAM | (pos[4] ? LCD_ROW1_BASE : 8'h00) | {4'h0, pos[3:0]};
    endfunction

    // Power-up command list, issued in index order
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = LCD_CMD_FUNCSET;
            2'd1:    init_cmd = LCD_CMD_DISPON;
            2'd2:    init_cmd = LCD_CMD_ENTRY;
            2'd3:    init_cmd = LCD_CMD_CLEAR;
            default: init_cmd = LCD_CMD_FUNCSET;
        endcase
    endfunction

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Client request handshake plus LCD bus bundle.
//   req/pos/char/ack x2 : single-character write requests from two clients
//   init_done           : power-up sequence finished
//   LCD_E/RS/RW/DATA    : character-LCD bus
// master = client side (drives requests, observes the bus), slave = arbiter.
interface lcd_write_arbiter_if;
    logic       req0;
    logic [4:0] pos0;
    logic [7:0] char0;
    logic       ack0;
    logic       req1;
    logic [4:0] pos1;
    logic [7:0] char1;
    logic       ack1;
    logic       init_done;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    modport master (
        output req0, pos0, char0, req1, pos1, char1,
        input  ack0, ack1, init_done, LCD_E, LCD_RS, LCD_RW, LCD_DATA
    );

    modport slave (
        input  req0, pos0, char0, req1, pos1, char1,
        output ack0, ack1, init_done, LCD_E, LCD_RS, LCD_RW, LCD_DATA
    );
endinterface

// File: rtl/lcd_bus_xfer.sv
// One LCD bus transfer: SETUP (E low), PULSE (E high), HOLD (E low).
//   start_i/rs_i/data_i : launch a transfer (accepted when ready_o is high)
//   clear_wait_i        : use the long post-pulse wait (clear command)
//   lcd_e_o/rs_o/data_o : registered LCD bus outputs
//   ready_o             : idle, or in the last HOLD cycle (back-to-back start)
//   done_o              : last HOLD cycle of the current transfer
module lcd_bus_xfer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned E_CYC        = 2,
    parameter int unsigned WAIT_CYC     = 4,
    parameter int unsigned CLR_WAIT_CYC = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    input  logic       clear_wait_i,
    output logic       lcd_e_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_data_o,
    output logic       ready_o,
    output logic       done_o
);
    // Down-counters load N-1 so each phase lasts exactly N cycles
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] E_LD     = 8'(E_CYC - 1);
    localparam logic [7:0] WAIT_LD  = 8'(WAIT_CYC - 1);
    localparam logic [7:0] CLR_LD   = 8'(CLR_WAIT_CYC - 1);

    logic [1:0] phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d;
    logic       e_q, e_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       clr_q, clr_d;
    logic       done_s;

    assign done_s     = (phase_q == PH_HOLD) && (cnt_q == 8'd0);
    assign done_o     = done_s;
    assign ready_o    = (phase_q == PH_IDLE) || done_s;
    assign lcd_e_o    = e_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;

    // Phase sequencing and per-phase cycle counting
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        clr_d   = clr_q;
        if (start_i && ((phase_q == PH_IDLE) || done_s)) begin
            phase_d = PH_SETUP;
            cnt_d   = SETUP_LD;
            e_d     = 1'b0;
            rs_d    = rs_i;
            data_d  = data_i;
            clr_d   = clear_wait_i;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    e_d = 1'b0;
                end
                PH_SETUP: begin
                    if (cnt_q == 8'd0) begin
                        phase_d = PH_PULSE;
                        cnt_d   = E_LD;
                        e_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                PH_PULSE: begin
                    if (cnt_q == 8'd0) begin
                        phase_d = PH_HOLD;
                        cnt_d   = clr_q ? CLR_LD : WAIT_LD;
                        e_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                PH_HOLD: begin
                    if (cnt_q == 8'd0) begin
                        phase_d = PH_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                    e_d     = 1'b0;
                end
            endcase
        end
    end

    // Transfer state and bus output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q <= PH_IDLE;
            cnt_q   <= 8'd0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            clr_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            clr_q   <= clr_d;
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Sole owner of the character-LCD bus. Runs the HD44780 power-up sequence,
// then round-robin arbitrates single-character writes from two clients and
// turns each into an optional set-DDRAM-address command plus a data write.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : client handshakes, init_done and the LCD bus
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned E_CYC        = 2,
    parameter int unsigned WAIT_CYC     = 4,
    parameter int unsigned CLR_WAIT_CYC = 16
) (
    input  logic                clk,
    input  logic                resetn,
    lcd_write_arbiter_if.slave  bus
);
    logic [1:0] state_q, state_d;
    logic [2:0] init_idx_q, init_idx_d;
    logic       init_done_q, init_done_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       last_grant_q, last_grant_d;
    logic [4:0] pos_q, pos_d;
    logic [7:0] char_q, char_d;
    logic [4:0] cursor_q, cursor_d;
    logic       cursor_valid_q, cursor_valid_d;

    logic       grant1_s;
    logic [4:0] sel_pos_s;
    logic [7:0] sel_char_s;
    logic       start_s, rs_s, clear_wait_s;
    logic [7:0] data_s;
    logic       xfer_ready_s, xfer_done_s;
    logic       lcd_e_s, lcd_rs_s;
    logic [7:0] lcd_data_s;

    // On a tie, client 1 wins only if client 0 was served last
    assign grant1_s   = bus.req1 & (~bus.req0 | ~last_grant_q);
    assign sel_pos_s  = grant1_s ? bus.pos1  : bus.pos0;
    assign sel_char_s = grant1_s ? bus.char1 : bus.char0;

    lcd_bus_xfer #(
        .SETUP_CYC    (SETUP_CYC),
        .E_CYC        (E_CYC),
        .WAIT_CYC     (WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC)
    ) u_xfer (
        .clk          (clk),
        .resetn       (resetn),
        .start_i      (start_s),
        .rs_i         (rs_s),
        .data_i       (data_s),
        .clear_wait_i (clear_wait_s),
        .lcd_e_o      (lcd_e_s),
        .lcd_rs_o     (lcd_rs_s),
        .lcd_data_o   (lcd_data_s),
        .ready_o      (xfer_ready_s),
        .done_o       (xfer_done_s)
    );

    assign bus.LCD_E     = lcd_e_s;
    assign bus.LCD_RS    = lcd_rs_s;
    assign bus.LCD_DATA  = lcd_data_s;
    assign bus.LCD_RW    = 1'b0;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.init_done = init_done_q;

    // Arbiter FSM: init sequencing, grant decision, cursor tracking
    always_comb begin
        state_d        = state_q;
        init_idx_d     = init_idx_q;
        init_done_d    = init_done_q;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        last_grant_d   = last_grant_q;
        pos_d          = pos_q;
        char_d         = char_q;
        cursor_d       = cursor_q;
        cursor_valid_d = cursor_valid_q;
        start_s        = 1'b0;
        rs_s           = 1'b0;
        data_s         = 8'h00;
        clear_wait_s   = 1'b0;
        case (state_q)
            ST_INIT_XFER: begin
                if (xfer_ready_s) begin
                    if (init_idx_q == 3'd4) begin
                        // Clear has finished: home position is known
                        state_d        = ST_IDLE;
                        init_done_d    = 1'b1;
                        cursor_d       = 5'd0;
                        cursor_valid_d = 1'b1;
                    end else begin
                        start_s      = 1'b1;
                        data_s       = init_cmd(init_idx_q[1:0]);
                        clear_wait_s = (init_idx_q == 3'd3);
                        init_idx_d   = init_idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_INIT_XFER;
                end
            end
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    ack0_d       = ~grant1_s;
                    ack1_d       = grant1_s;
                    last_grant_d = grant1_s;
                    pos_d        = sel_pos_s;
                    char_d       = sel_char_s;
                    start_s      = 1'b1;
                    if (cursor_valid_q && (sel_pos_s == cursor_q)) begin
                        rs_s    = 1'b1;
                        data_s  = sel_char_s;
                        state_d = ST_DATA_XFER;
                    end else begin
                        data_s  = ddram_cmd(sel_pos_s);
                        state_d = ST_ADDR_XFER;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR_XFER: begin
                if (xfer_done_s) begin
                    start_s = 1'b1;
                    rs_s    = 1'b1;
                    data_s  = char_q;
                    state_d = ST_DATA_XFER;
                end else begin
                    state_d = ST_ADDR_XFER;
                end
            end
            ST_DATA_XFER: begin
                if (xfer_done_s) begin
                    state_d = ST_IDLE;
                    // The controller does not wrap into the other row, so the
                    // cursor position after column 15 is treated as unknown
                    if (pos_q[3:0] == 4'hF) begin
                        cursor_valid_d = 1'b0;
                    end else begin
                        cursor_d       = {pos_q[4], pos_q[3:0] + 4'h1};
                        cursor_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_DATA_XFER;
                end
            end
            default: begin
                state_d = ST_INIT_XFER;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_INIT_XFER;
            init_idx_q     <= 3'd0;
            init_done_q    <= 1'b0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            last_grant_q   <= 1'b1;
            pos_q          <= 5'd0;
            char_q         <= 8'h00;
            cursor_q       <= 5'd0;
            cursor_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_idx_q     <= init_idx_d;
            init_done_q    <= init_done_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            last_grant_q   <= last_grant_d;
            pos_q          <= pos_d;
            char_q         <= char_d;
            cursor_q       <= cursor_d;
            cursor_valid_q <= cursor_valid_d;
        end
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with default timing (T = 7 cycles).
module tb_lcd_write_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    lcd_write_arbiter_if bus();

    lcd_write_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Observed bus transfers: {rs,data}, E-high length, cycle of E rise
    logic [8:0] xf[$];
    int         xf_len[$];
    int         xf_rise[$];
    int         ack_who[$];
    int         ack_wide = 0;
    int         rw_bad = 0;
    int         unstable = 0;
    logic       e_prev = 1'b0;
    logic       a0_prev = 1'b0;
    logic       a1_prev = 1'b0;
    logic [8:0] m_word = 9'h000;
    int         m_len = 0;
    int         m_rise = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus and ack monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!resetn) begin
            e_prev  <= 1'b0;
            a0_prev <= 1'b0;
            a1_prev <= 1'b0;
        end else begin
            if (bus.LCD_E === 1'b1 && !e_prev) begin
                m_word <= {bus.LCD_RS, bus.LCD_DATA};
                m_len  <= 1;
                m_rise <= cyc;
            end else if (bus.LCD_E === 1'b1) begin
                m_len <= m_len + 1;
                if ({bus.LCD_RS, bus.LCD_DATA} !== m_word) unstable <= unstable + 1;
            end else if (e_prev) begin
                xf.push_back(m_word);
                xf_len.push_back(m_len);
                xf_rise.push_back(m_rise);
            end
            e_prev <= (bus.LCD_E === 1'b1);
            if (bus.LCD_RW !== 1'b0) rw_bad <= rw_bad + 1;
            if (bus.ack0 === 1'b1 && a0_prev) ack_wide <= ack_wide + 1;
            if (bus.ack1 === 1'b1 && a1_prev) ack_wide <= ack_wide + 1;
            if (bus.ack0 === 1'b1 && !a0_prev) ack_who.push_back(0);
            if (bus.ack1 === 1'b1 && !a1_prev) ack_who.push_back(1);
            a0_prev <= (bus.ack0 === 1'b1);
            a1_prev <= (bus.ack1 === 1'b1);
        end
    end

    task automatic clear_logs();
        xf.delete();
        xf_len.delete();
        xf_rise.delete();
        ack_who.delete();
    endtask

    // Raise a request, wait for its ack, then release it
    task automatic do_req(input int c, input logic [4:0] p, input logic [7:0] ch, output int at);
        bit got;
        got = 1'b0;
        at  = -1;
        @(negedge clk);
        if (c == 0) begin bus.req0 = 1'b1; bus.pos0 = p; bus.char0 = ch; end
        else        begin bus.req1 = 1'b1; bus.pos1 = p; bus.char1 = ch; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((c == 0 && bus.ack0 === 1'b1) || (c == 1 && bus.ack1 === 1'b1)) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        if (c == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL ack_timeout: client %0d saw no ack, required one", c);
        end
    endtask

    task automatic test_reset();
        int rel;
        logic [8:0] exp_w [4];
        exp_w = '{9'h038, 9'h00C, 9'h006, 9'h001};
        bus.req0 = 1'b0; bus.pos0 = 5'd0; bus.char0 = 8'h00;
        bus.req1 = 1'b0; bus.pos1 = 5'd0; bus.char1 = 8'h00;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA, bus.ack0, bus.ack1, bus.init_done} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got E=%b RS=%b RW=%b D=%h ack=%b%b done=%b, required all 0",
                     bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA, bus.ack0, bus.ack1, bus.init_done);
        end
        clear_logs();
        rel = cyc;
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.init_done !== 1'b0) begin
            n_bad++;
            $display("FAIL init_done_early: got %b at cycle 39, required 0", bus.init_done);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.init_done !== 1'b1) begin
            n_bad++;
            $display("FAIL init_done_rise: got %b at cycle 40, required 1", bus.init_done);
        end
        n_cmp++;
        if (xf.size() != 4) begin
            n_bad++;
            $display("FAIL init_count: got %0d transfers, required 4", xf.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= xf.size() || xf[i] !== exp_w[i] || xf_len[i] != 2) begin
                n_bad++;
                $display("FAIL init_cmd_%0d: got rs/data %h E-len %0d, required %h E-len 2",
                         i, (i < xf.size()) ? xf[i] : 9'h1FF, (i < xf.size()) ? xf_len[i] : -1, exp_w[i]);
            end
        end
        n_cmp++;
        if (xf.size() < 4 || xf_rise[0] != rel + 2 || xf_rise[3] != rel + 23) begin
            n_bad++;
            $display("FAIL init_timing: got first/clear E rise offsets %0d/%0d, required 1/22",
                     (xf.size() > 0) ? xf_rise[0] - rel - 1 : -1, (xf.size() > 3) ? xf_rise[3] - rel - 1 : -1);
        end
    endtask

    task automatic test_addr_then_skip();
        int a1, a2;
        logic [8:0] exp_w [3];
        exp_w = '{9'h0C3, 9'h131, 9'h132};
        a1 = -1;
        a2 = -1;
        clear_logs();
        @(negedge clk);
        bus.req0 = 1'b1; bus.pos0 = 5'b1_0011; bus.char0 = 8'h31;
        for (int i = 0; i < 50 && a1 < 0; i++) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1) a1 = cyc;
        end
        // req0 stays high with new data: it is a fresh request at the cursor
        bus.pos0 = 5'b1_0100; bus.char0 = 8'h32;
        for (int i = 0; i < 50 && a2 < 0; i++) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1) a2 = cyc;
        end
        bus.req0 = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (a1 < 0 || a2 < 0) begin
            n_bad++;
            $display("FAIL req0_acks: got ack cycles %0d/%0d, required two acks", a1, a2);
        end
        n_cmp++;
        if (xf.size() != 3) begin
            n_bad++;
            $display("FAIL req0_count: got %0d transfers, required 3", xf.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= xf.size() || xf[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL req0_xfer_%0d: got rs/data %h, required %h",
                         i, (i < xf.size()) ? xf[i] : 9'h1FF, exp_w[i]);
            end
        end
        n_cmp++;
        if (xf.size() < 3 || xf_rise[0] != a1 + 1 || xf_rise[1] != a1 + 8 || a2 != a1 + 15 || xf_rise[2] != a2 + 1) begin
            n_bad++;
            $display("FAIL req0_latency: got ack2-ack1=%0d, required 15 with E rises at +1/+8/+1", a2 - a1);
        end
    endtask

    task automatic test_client1();
        int a;
        do_req(1, 5'b0_0000, 8'h41, a);
        repeat (14) @(negedge clk);
        n_cmp++;
        if (xf.size() != 5 || xf[3] !== 9'h080 || xf[4] !== 9'h141 || ack_who.size() != 3 || ack_who[2] != 1) begin
            n_bad++;
            $display("FAIL client1_write: got %0d transfers, last %h, required 080 then 141 acked by client 1",
                     xf.size(), (xf.size() > 0) ? xf[xf.size() - 1] : 9'h1FF);
        end
    endtask

    task automatic test_back_to_back();
        int exp_who [4];
        logic [8:0] exp_w [7];
        exp_who = '{0, 1, 0, 1};
        exp_w   = '{9'h161, 9'h0C1, 9'h162, 9'h081, 9'h161, 9'h0C1, 9'h162};
        clear_logs();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            bus.req0 = 1'b1; bus.pos0 = 5'b0_0001; bus.char0 = 8'h61;
            bus.req1 = 1'b1; bus.pos1 = 5'b1_0001; bus.char1 = 8'h62;
            for (int i = 0; i < 100 && (bus.req0 || bus.req1); i++) begin
                @(negedge clk);
                if (bus.ack0 === 1'b1) bus.req0 = 1'b0;
                if (bus.ack1 === 1'b1) bus.req1 = 1'b0;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (ack_who.size() != 4) begin
            n_bad++;
            $display("FAIL tie_ack_count: got %0d acks, required 4", ack_who.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= ack_who.size() || ack_who[i] != exp_who[i]) begin
                n_bad++;
                $display("FAIL tie_order_%0d: got client %0d, required %0d",
                         i, (i < ack_who.size()) ? ack_who[i] : -1, exp_who[i]);
            end
        end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (i >= xf.size() || xf[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL tie_xfer_%0d: got rs/data %h, required %h",
                         i, (i < xf.size()) ? xf[i] : 9'h1FF, exp_w[i]);
            end
        end
    endtask

    task automatic test_row_end();
        int a;
        logic [8:0] exp_w [4];
        exp_w = '{9'h08F, 9'h178, 9'h0C0, 9'h179};
        clear_logs();
        do_req(0, 5'b0_1111, 8'h78, a);
        do_req(0, 5'b1_0000, 8'h79, a);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (xf.size() != 4) begin
            n_bad++;
            $display("FAIL row_end_count: got %0d transfers, required 4", xf.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= xf.size() || xf[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL row_end_xfer_%0d: got rs/data %h, required %h",
                         i, (i < xf.size()) ? xf[i] : 9'h1FF, exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int rel, a;
        bit got;
        logic idone;
        logic [8:0] exp_w [6];
        exp_w = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h085, 9'h17A};
        got = 1'b0;
        a = -1;
        idone = 1'b0;
        clear_logs();
        @(negedge clk);
        bus.req1 = 1'b1; bus.pos1 = 5'b0_0110; bus.char1 = 8'h55;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.LCD_E === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL pulse_timeout: got no E pulse, required one");
        end
        #2;
        resetn = 1'b0;
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.pos0 = 5'b0_0101; bus.char0 = 8'h7A;
        #1;
        n_cmp++;
        if ({bus.LCD_E, bus.LCD_RS, bus.LCD_DATA, bus.ack0, bus.ack1, bus.init_done} !== 13'h0) begin
            n_bad++;
            $display("FAIL async_reset: got E=%b RS=%b D=%h done=%b, required all 0",
                     bus.LCD_E, bus.LCD_RS, bus.LCD_DATA, bus.init_done);
        end
        repeat (3) @(negedge clk);
        clear_logs();
        rel = cyc;
        resetn = 1'b1;
        for (int i = 0; i < 120 && a < 0; i++) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1) begin
                a = cyc;
                idone = bus.init_done;
            end
        end
        bus.req0 = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (a != rel + 42 || idone !== 1'b1) begin
            n_bad++;
            $display("FAIL held_req_ack: got ack at cycle %0d with init_done=%b, required cycle 41 with 1",
                     a - rel - 1, idone);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= xf.size() || xf[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL restart_xfer_%0d: got rs/data %h, required %h",
                         i, (i < xf.size()) ? xf[i] : 9'h1FF, exp_w[i]);
            end
        end
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (rw_bad != 0 || unstable != 0 || ack_wide != 0) begin
            n_bad++;
            $display("FAIL bus_invariants: got RW!=0 %0d, RS/DATA changes in pulse %0d, long acks %0d, required 0/0/0",
                     rw_bad, unstable, ack_wide);
        end
    endtask

    initial begin
        test_reset();
        test_addr_then_skip();
        test_client1();
        test_back_to_back();
        test_row_end();
        test_reset_mid_pulse();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Sole owner of the character-LCD bus (LCD_E, LCD_RS, LCD_RW, LCD_DATA) in the clock/alarm design.
- After reset it runs the HD44780 power-up command sequence.
- It then round-robin arbitrates single-character write requests from two clients (time display, keypad echo) and sequences each request into a DDRAM-address command plus a data write, with programmable E-pulse timing.
- It skips the address command when the target position equals the tracked cursor.

Parameters:
- SETUP_CYC, 1, cycles RS/DATA stable with E low before the E pulse (1..255)
- E_CYC, 2, cycles LCD_E held high (1..255)
- WAIT_CYC, 4, cycles E low after the pulse before the next transfer (1..255)
- CLR_WAIT_CYC, 16, post-pulse wait used only after the clear command 0x01 (1..255)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req0  in  1  client 0 request; held with pos0/char0 stable until ack0
- pos0  in  5  client 0 position: bit4 = row, bits3:0 = column
- char0  in  8  client 0 ASCII code
- ack0  out  1  one-cycle pulse; client 0 request latched
- req1, pos1, char1, ack1  same as client 0, for client 1
- init_done  out  1  high once the init sequence completes; stays high until reset
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  tied 0 (write only)
- LCD_DATA  out  8  LCD data bus

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00, ack0=ack1=0, init_done=0, cursor_valid=0, last_grant=1.
- Reset asserted mid-transfer forces all outputs to reset values immediately. On release, the init sequence restarts from the first command.

Bus transfer (shared by all commands and data writes):
- SETUP: E=0, RS/DATA driven, for SETUP_CYC cycles.
- PULSE: E=1, for E_CYC cycles.
- HOLD: E=0, for WAIT_CYC cycles (CLR_WAIT_CYC for 0x01).
- RS and DATA hold constant across all three phases. Per-phase down-counter is 8 bits wide.
- Transfer length T = SETUP_CYC + E_CYC + WAIT_CYC = 7 cycles with defaults.

Init sequence:
- Commands issued in order: 0x38, 0x0C, 0x06, 0x01.
- First SETUP cycle is the first clock after resetn rises.
- init_done rises the cycle after the 0x01 HOLD ends: 3T + SETUP_CYC + E_CYC + CLR_WAIT_CYC = 40 cycles with defaults.
- The clear sets cursor = row 0, col 0 and cursor_valid=1.
- Requests arriving during init are ignored (no ack) and serviced once IDLE is reached.

FSM states: INIT_XFER, IDLE, ADDR_XFER, DATA_XFER.
- IDLE, grant rule:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the client other than last_grant, so client 0 wins the first tie after reset.
- Grant cycle:
  - ackN pulses for exactly 1 cycle.
  - pos/char are latched.
  - last_grant is updated.
- Next state after grant:
  - Latched pos equals cursor and cursor_valid=1: go to DATA_XFER.
  - Otherwise: go to ADDR_XFER with command 0x80 | (row ? 0x40 : 0x00) | col.
- ADDR_XFER then DATA_XFER (RS=1, DATA = latched char), then return to IDLE.
  - A new grant is possible in that first IDLE cycle, so there is no dead cycle beyond the IDLE check.
- Cursor tracking after each data write:
  - col < 15: col increments.
  - col == 15: cursor_valid=0, because the controller row does not wrap to the other row. The next write always issues an address command.
- Latency per request, grant to end of DATA HOLD: 2T = 14 cycles with address command, T = 7 cycles without.
- A client keeping req high after ack is treated as a new request.

Decomposition:
- Shared package lcd_pkg holds:
  - Command constants: LCD_CMD_FUNCSET=8'h38, LCD_CMD_DISPON=8'h0C, LCD_CMD_ENTRY=8'h06, LCD_CMD_CLEAR=8'h01, LCD_CMD_DDRAM=8'h80, LCD_ROW1_BASE=8'h40.
  - FSM state encoding.
- One sub-module, lcd_bus_xfer:
  - Inputs: start, rs, data, clear_wait.
  - Outputs: E/RS/DATA, done pulse.
  - Implements the SETUP/PULSE/HOLD timing.
  - The arbiter FSM drives it.

Test Plan:
1. Reset, no requests → LCD_DATA sequence 38,0C,06,01 with RS=0, each E high exactly 2 cycles; init_done rises at cycle 40; LCD_RW=0 throughout.
2. After init, req0 with pos=5'b1_0011, char=8'h31 → ack0 one cycle; bus shows command 0xC3 (RS=0) then data 0x31 (RS=1); back to IDLE 14 cycles after ack.
3. Then req0 with pos=5'b1_0100, char=8'h32 → no address command; single data transfer 0x32, 7 cycles.
4. req0 and req1 asserted in the same cycle, twice in succession → grant order 0,1,0,1; no dropped or duplicated acks.
5. Write at pos=5'b0_1111, then pos=5'b1_0000 → second write issues address command 0xC0.
6. resetn pulsed low mid-PULSE → LCD_E drops immediately; init restarts with 0x38; a request held across reset is acked only after init_done.
